// File: rtl/arrow_spawner.sv
// Arrow launcher: paces launches by frame count, picks direction/speed/inversion
// from an LFSR, and keeps score, lives and game-over state for one arrow instance.
module arrow_spawner #(
  parameter int          LIVES          = 3,
  parameter int          GAP_FRAMES     = 90,
  parameter int          MIN_GAP_FRAMES = 20,
  parameter int          TIMEOUT_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          INVERSE_EN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start,
  input  logic        is_hit,
  input  logic        hit_player,
  output logic        valid_out,
  output logic [1:0]  direction_out,
  output logic [2:0]  speed_out,
  output logic        inversed_out,
  output logic [7:0]  score_out,
  output logic [1:0]  lives_out,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    ARM       = 3'd2,
    FLIGHT    = 3'd3,
    RETIRE    = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  score_reg, score_next;
  logic [1:0]  lives_reg, lives_next;
  logic [1:0]  dir_reg, dir_next;
  logic [2:0]  speed_reg, speed_next;
  logic        inv_reg, inv_next;
  logic        first_reg, first_next;
  logic        valid_reg, game_over_reg;

  logic        frame_tick;
  logic [15:0] shrink;
  logic [15:0] gap_frames;
  logic [2:0]  speed_calc;

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Gap shrinks by 4 frames per 4 points; compared before subtracting so it never wraps.
  assign shrink     = {8'd0, score_reg[7:2], 2'b00};
  assign gap_frames = (16'(GAP_FRAMES) >= shrink + 16'(MIN_GAP_FRAMES))
                      ? 16'(GAP_FRAMES) - shrink : 16'(MIN_GAP_FRAMES);
  assign speed_calc = (score_reg[7:3] >= 5'd6) ? 3'd7 : 3'(score_reg[7:3] + 5'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 16'd0;
      score_reg     <= 8'd0;
      lives_reg     <= 2'd0;
      dir_reg       <= 2'd0;
      speed_reg     <= 3'd0;
      inv_reg       <= 1'b0;
      first_reg     <= 1'b0;
      valid_reg     <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      score_reg     <= score_next;
      lives_reg     <= lives_next;
      dir_reg       <= dir_next;
      speed_reg     <= speed_next;
      inv_reg       <= inv_next;
      first_reg     <= first_next;
      valid_reg     <= (state_next == FLIGHT);
      game_over_reg <= (state_next == GAME_OVER);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    score_next = score_reg;
    lives_next = lives_reg;
    dir_next   = dir_reg;
    speed_next = speed_reg;
    inv_next   = inv_reg;
    first_next = 1'b0;
    case (state_reg)
      IDLE, GAME_OVER: begin
        if (start) begin
          lives_next = 2'(LIVES);
          score_next = 8'd0;
          cnt_next   = 16'd0;
          state_next = GAP;
        end
      end
      GAP: begin
        if (frame_tick) begin
          if (cnt_reg + 16'd1 >= gap_frames) begin
            cnt_next   = 16'd0;
            state_next = ARM;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      ARM: begin
        dir_next   = lfsr_reg[1:0];
        inv_next   = (INVERSE_EN != 0) && (lfsr_reg[1:0] == 2'b00) && lfsr_reg[2]
                     && (score_reg >= 8'd8);
        speed_next = speed_calc;
        cnt_next   = 16'd0;
        first_next = 1'b1;
        state_next = FLIGHT;
      end
      FLIGHT: begin
        // A hit level left over from the previous arrow is not a result for this one.
        if (is_hit && !first_reg) begin
          if (hit_player) begin
            lives_next = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
          end else if (score_reg != 8'hFF) begin
            score_next = score_reg + 8'd1;
          end
          state_next = RETIRE;
        end else if (frame_tick) begin
          cnt_next = cnt_reg + 16'd1;
          if (cnt_reg + 16'd1 >= 16'(TIMEOUT_FRAMES)) begin
            state_next = RETIRE;
          end
        end
      end
      RETIRE: begin
        cnt_next   = 16'd0;
        state_next = (lives_reg == 2'd0) ? GAME_OVER : GAP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign valid_out     = valid_reg;
  assign direction_out = dir_reg;
  assign speed_out     = speed_reg;
  assign inversed_out  = inv_reg;
  assign score_out     = score_reg;
  assign lives_out     = lives_reg;
  assign game_over     = game_over_reg;

endmodule

// File: tb/tb_arrow_spawner.sv
// Directed-plus-random bench for arrow_spawner; expectations come from a
// game-rule model (score/lives counters, gap formula, reference LFSR sequence).
module tb_arrow_spawner;
  localparam int          LIVES   = 3;
  localparam int          GAP     = 90;
  localparam int          MIN_GAP = 20;
  localparam int          TIMEOUT = 600;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = 11'd5;
  logic [9:0]  vcount_in = 10'd5;
  logic        start = 1'b0;
  logic        is_hit = 1'b0;
  logic        hit_player = 1'b0;
  logic        valid_out;
  logic [1:0]  direction_out;
  logic [2:0]  speed_out;
  logic        inversed_out;
  logic [7:0]  score_out;
  logic [1:0]  lives_out;
  logic        game_over;

  arrow_spawner dut (
    .clk          (clk),
    .rst          (rst),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .start        (start),
    .is_hit       (is_hit),
    .hit_player   (hit_player),
    .valid_out    (valid_out),
    .direction_out(direction_out),
    .speed_out    (speed_out),
    .inversed_out (inversed_out),
    .score_out    (score_out),
    .lives_out    (lives_out),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int m_score    = 0;
  int m_lives    = 0;
  logic [15:0] lfsr_cur, lfsr_prev;
  int e_dir, e_speed, e_inv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int x;
    int b;
    x = int'(v);
    b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (b << 15));
  endfunction

  // One clock edge; the model LFSR follows the same edge, then outputs settle.
  task automatic step();
    @(posedge clk);
    lfsr_prev = lfsr_cur;
    lfsr_cur  = rst ? lfsr_step(lfsr_cur) : SEED;
    #1;
  endtask

  task automatic set_frame(input bit tick);
    if (tick) begin
      hcount_in = 11'd0;
      vcount_in = 10'd0;
    end else begin
      case ($urandom_range(0, 2))
        0: begin hcount_in = 11'd0; vcount_in = 10'($urandom_range(1, 524)); end
        1: begin hcount_in = 11'($urandom_range(1, 799)); vcount_in = 10'd0; end
        default: begin
          hcount_in = 11'($urandom_range(1, 799));
          vcount_in = 10'($urandom_range(1, 524));
        end
      endcase
    end
  endtask

  function automatic int exp_gap(input int s);
    int g;
    g = GAP - 4 * (s >> 2);
    return (g > MIN_GAP) ? g : MIN_GAP;
  endfunction

  // From GAP: deliver exactly gap frame ticks, expect valid one ARM cycle later.
  task automatic launch();
    int gap;
    int n;
    int lat;
    bit t;
    gap = exp_gap(m_score);
    n   = 0;
    lat = -1;
    for (int c = 0; c < gap * 8 + 50; c++) begin
      t = (n < gap) && ($urandom_range(0, 3) != 0);
      set_frame(t);
      start      = ($urandom_range(0, 63) == 0);
      hit_player = ($urandom_range(0, 63) == 0);
      step();
      start      = 1'b0;
      hit_player = 1'b0;
      if (t) begin
        n++;
        if (n == gap) lat = 0;
      end else if (lat >= 0) begin
        lat++;
      end
      if (valid_out === 1'b1) break;
    end
    check("launch_ticks", n, gap);
    check("launch_latency", lat, 1);
    e_dir   = int'(lfsr_prev[1:0]);
    e_inv   = (lfsr_prev[1:0] == 2'b00 && lfsr_prev[2] && m_score >= 8) ? 1 : 0;
    e_speed = (1 + (m_score >> 3) > 7) ? 7 : 1 + (m_score >> 3);
    $display("launch score=%0d gap=%0d dir=%0d speed=%0d inv=%0d", m_score, gap, direction_out, speed_out, inversed_out);
    check("launch_dir", direction_out, e_dir);
    check("launch_speed", speed_out, e_speed);
    check("launch_inv", inversed_out, e_inv);
    // Stale is_hit (possibly still high) on the first FLIGHT cycle must be ignored.
    set_frame(0);
    step();
    check("stale_hit_valid", valid_out, 1);
    check("stale_hit_score", score_out, m_score);
    is_hit = 1'b0;
  endtask

  task automatic fly(input bit player);
    int k;
    k = $urandom_range(0, 15);
    for (int i = 0; i < k; i++) begin
      set_frame($urandom_range(0, 1) == 1);
      step();
    end
    check("flight_valid", valid_out, 1);
    check("flight_attrs", {direction_out, speed_out, inversed_out}, {e_dir[1:0], e_speed[2:0], e_inv[0]});
    set_frame(0);
    is_hit     = 1'b1;
    hit_player = player;
    step();
    hit_player = 1'b0;
    if (player) m_lives = m_lives - 1;
    else if (m_score < 255) m_score = m_score + 1;
    $display("resolve player=%0d score=%0d lives=%0d valid=%0d", player, score_out, lives_out, valid_out);
    check("hit_valid_fall", valid_out, 0);
    check("hit_score", score_out, m_score);
    check("hit_lives", lives_out, m_lives);
    step();
    check("retire_game_over", game_over, (m_lives == 0) ? 1 : 0);
  endtask

  task automatic timeout_flight();
    int n;
    n = 0;
    is_hit = 1'b0;
    for (int c = 0; c < TIMEOUT + 100; c++) begin
      set_frame(1);
      step();
      n++;
      if (valid_out !== 1'b1) break;
    end
    $display("timeout after %0d frames score=%0d lives=%0d", n, score_out, lives_out);
    check("timeout_frames", n, TIMEOUT);
    check("timeout_score", score_out, m_score);
    check("timeout_lives", lives_out, m_lives);
    set_frame(0);
    step();
    check("timeout_retire_game_over", game_over, 0);
  endtask

  task automatic pulse_start();
    set_frame(0);
    start = 1'b1;
    step();
    start   = 1'b0;
    m_score = 0;
    m_lives = LIVES;
    $display("start score=%0d lives=%0d game_over=%0d", score_out, lives_out, game_over);
    check("start_lives", lives_out, LIVES);
    check("start_score", score_out, 0);
    check("start_game_over", game_over, 0);
  endtask

  initial begin
    int anyv;
    // Reset from power-up.
    rst = 1'b0;
    repeat (3) step();
    check("reset_outputs",
          {valid_out, direction_out, speed_out, inversed_out, score_out, lives_out, game_over}, 0);
    rst = 1'b1;

    // IDLE never launches without start, even with frames and stray hit_player.
    anyv = 0;
    for (int i = 0; i < 40; i++) begin
      set_frame($urandom_range(0, 1) == 1);
      hit_player = ($urandom_range(0, 7) == 0);
      step();
      if (valid_out !== 1'b0) anyv = 1;
    end
    hit_player = 1'b0;
    check("idle_no_launch", anyv, 0);
    check("idle_lives", lives_out, 0);

    pulse_start();
    launch(); fly(0);
    launch(); fly(0);
    launch(); timeout_flight();
    launch(); fly(1);
    launch(); fly(1);
    launch(); fly(1);

    // GAME_OVER: no launches, counters held.
    anyv = 0;
    for (int i = 0; i < 200; i++) begin
      set_frame($urandom_range(0, 1) == 1);
      step();
      if (valid_out !== 1'b0) anyv = 1;
    end
    check("game_over_no_launch", anyv, 0);
    check("game_over_held", {game_over, lives_out, score_out}, {1'b1, 2'd0, 8'(m_score)});
    pulse_start();

    // Reset in the middle of a flight.
    launch();
    rst = 1'b0;
    step();
    check("midflight_reset_valid", valid_out, 0);
    step();
    step();
    check("midflight_reset_outputs",
          {valid_out, direction_out, speed_out, inversed_out, score_out, lives_out, game_over}, 0);
    rst     = 1'b1;
    is_hit  = 1'b0;
    m_score = 0;
    m_lives = 0;

    // Long run through the shrinking gap, speed cap and score saturation.
    pulse_start();
    for (int i = 0; i < 258; i++) begin
      launch();
      fly(0);
    end
    check("final_score_saturated", score_out, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arrow_spawner.md
Name: arrow_spawner

Overview:
- Initiator side of the arrow interface: decides when, from which direction and how each arrow is launched, drives the arrow's valid/direction/speed/inversed inputs, and consumes its is_hit / hit_player results.
- Keeps the score, lives and game-over state.
- Sits between the game top level (start button, score display) and one arrow instance; all timing is frame-based, using the same hcount/vcount as the renderer.

Parameters:
- LIVES, 3, lives loaded on start.
- GAP_FRAMES, 90, frames between retire and next launch at score 0.
- MIN_GAP_FRAMES, 20, floor for the shrinking gap.
- TIMEOUT_FRAMES, 600, maximum frames an arrow may stay in flight.
- LFSR_SEED, 16'hACE1, nonzero reset value of the direction LFSR.
- INVERSE_EN, 1, enables inversed (parabolic) arrows from direction 2'b00.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- hcount_in  input  11  pixel column
- vcount_in  input  10  pixel row
- start  input  1  one-cycle pulse; begins a game from IDLE or GAME_OVER
- is_hit  input  1  arrow resolved (level, held until next launch)
- hit_player  input  1  one-cycle pulse, coincident with is_hit rising when the player was hit
- valid_out  output  1  to arrow valid_in; rising edge launches an arrow
- direction_out  output  2  to arrow direction_in (00 top, 01 bottom, 10 left, 11 right)
- speed_out  output  3  to arrow speed_in
- inversed_out  output  1  to arrow inversed_in
- score_out  output  8  blocked arrows, saturating at 255
- lives_out  output  2  remaining lives
- game_over  output  1  high in GAME_OVER

Behaviour:
- Reset (rst==0 at a clk edge):
  - valid_out=0, direction_out=0, speed_out=0, inversed_out=0, score_out=0, lives_out=0, game_over=0.
  - LFSR=LFSR_SEED; state=IDLE; frame counter=0.
  - Reset mid-flight drops valid_out on the next edge.
- frame_tick: hcount_in==0 && vcount_in==0. All frame counts advance only on frame_tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clk regardless of state except during reset. Never zero.
- IDLE:
  - Outputs held.
  - On start: lives_out=LIVES, score_out=0, frame counter=0, go to GAP.
- GAP:
  - valid_out=0. Count frames.
  - gap = max(MIN_GAP_FRAMES, GAP_FRAMES - 4*(score_out>>2)), computed at 9+ bits with no underflow.
  - When the count reaches gap, go to ARM.
- ARM (exactly 1 cycle): valid_out stays 0; latch from the current LFSR:
  - direction_out=LFSR[1:0].
  - inversed_out = INVERSE_EN && LFSR[1:0]==2'b00 && LFSR[2] && score_out>=8.
  - speed_out = min(7, 1 + (score_out>>3)).
  - Go to FLIGHT.
- FLIGHT:
  - valid_out=1 starting on the first FLIGHT cycle, so the arrow sees a clean 0->1 edge. direction/speed/inversed are stable for the whole flight.
  - Count frames. On the first cycle with is_hit==1:
    - If hit_player==1 in that cycle: lives_out-1.
    - Else: score_out+1, saturating at 255.
    - Go to RETIRE.
  - is_hit already high on the first FLIGHT cycle (stale from the previous arrow) is ignored for that one cycle only.
  - If the frame count reaches TIMEOUT_FRAMES without is_hit: no score/lives change, go to RETIRE.
- RETIRE (exactly 1 cycle):
  - valid_out=0.
  - If lives_out==0: go to GAME_OVER. Else clear the frame counter and go to GAP.
- GAME_OVER:
  - game_over=1, valid_out=0; score/lives held.
  - On start: same action as from IDLE, and game_over drops on the same edge.
- start pulses in GAP/ARM/FLIGHT/RETIRE are ignored.
- A hit_player pulse arriving outside FLIGHT is ignored.
- Latency: start -> valid_out rise = gap frames + 1 ARM cycle. is_hit -> valid_out fall = 1 cycle.

Test Plan:
- Reset with rst=0 for 3 cycles mid-FLIGHT -> valid_out=0, lives_out=0, score_out=0, state IDLE on the next edge.
- start; drive 90 frame_ticks; hold is_hit=0 -> valid_out rises 1 cycle after the 90th tick. direction_out equals LFSR[1:0] sampled in ARM and is stable until valid falls.
- In FLIGHT, pulse is_hit=1 with hit_player=0 -> score_out 0->1, valid_out=0 next cycle. Next gap is 90 frames (score 1 -> 90-0).
- Three launches each ending with is_hit=1, hit_player=1 -> lives_out 3->2->1->0, game_over=1, no further valid_out rise. A start pulse then gives lives_out=3, score_out=0, game_over=0.
- Hold is_hit=0 for 600 frames in FLIGHT -> retire via timeout with score/lives unchanged, and a new launch after the gap.
- Force score_out=80 -> gap=MIN_GAP_FRAMES=20, speed_out=7 (min(7,11)). Inversed arrows appear only with direction_out=00. Score at 255 plus a block stays 255.
